input_conditioner: RTL

Front-end stage that sits directly upstream of the game/VGA top. It takes the five raw push-button inputs (up, down, left, right, jump), synchronises and debounces them, and produces clean levels plus one-cycle press/release pulses. It also runs the jump-charge logic: holding jump charges a power value, and releasing it emits a single fire pulse carrying the latched power for the player physics stage.

---
 rtl/input_conditioner_pkg.sv | 15 +
 rtl/debounce_cell.sv | 46 ++++
 rtl/input_conditioner.sv | 90 +++++++++
 3 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared button map and charge defaults for the input conditioner and the
// downstream physics stage.
package input_conditioner_pkg;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_JUMP  = 4;
    localparam int unsigned NUM_BTN   = 5;

    localparam int unsigned CHARGE_W_DEFAULT   = 5;
    localparam int unsigned CHARGE_MAX_DEFAULT = 31;

endpackage

// File: rtl/debounce_cell.sv
// One-bit 2-FF synchroniser plus counter-based debouncer; exposes the stable
// level and single-cycle strobes for the edge that flips it.
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic             sync1;
    logic             synced;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // Strobes are high in the cycle before level changes so the parent can
    // register them alongside the new level.
    assign flip = (synced != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign rise = flip & synced;
    assign fall = flip & ~synced;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            synced <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync1  <= raw;
            synced <= sync1;
            if (synced == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Button front end: per-bit debounce with registered press/release pulses,
// plus jump charge accumulation and a fire pulse carrying the latched power.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned CHARGE_DIV      = 4,
    parameter int unsigned CHARGE_MAX      = CHARGE_MAX_DEFAULT,
    parameter int unsigned CHARGE_W        = CHARGE_W_DEFAULT
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_BTN-1:0]  btn_in,
    output logic [NUM_BTN-1:0]  btn_level,
    output logic [NUM_BTN-1:0]  btn_press,
    output logic [NUM_BTN-1:0]  btn_release,
    output logic                jump_charging,
    output logic [CHARGE_W-1:0] jump_charge,
    output logic                jump_fire,
    output logic [CHARGE_W-1:0] jump_power
);

    localparam int unsigned PRE_W = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;

    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] fall;
    logic [PRE_W-1:0]   presc;
    logic               jump_fall;

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_cell (
                .clk  (sys_clk),
                .rst  (sys_rst),
                .raw  (btn_in[g]),
                .level(btn_level[g]),
                .rise (rise[g]),
                .fall (fall[g])
            );
        end
    endgenerate

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_press   <= rise;
            btn_release <= fall;
        end
    end

    assign jump_charging = btn_level[BTN_JUMP];
    assign jump_fall     = fall[BTN_JUMP];

    // Release takes priority over a coinciding prescaler wrap, so the
    // captured power is always the pre-increment charge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            presc       <= '0;
            jump_charge <= '0;
            jump_fire   <= 1'b0;
            jump_power  <= '0;
        end else begin
            jump_fire <= 1'b0;
            if (jump_fall) begin
                jump_fire   <= 1'b1;
                jump_power  <= jump_charge;
                jump_charge <= '0;
                presc       <= '0;
            end else if (btn_level[BTN_JUMP]) begin
                if (presc == PRE_W'(CHARGE_DIV - 1)) begin
                    presc <= '0;
                    if (jump_charge != CHARGE_W'(CHARGE_MAX))
                        jump_charge <= jump_charge + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end else begin
                presc <= '0;
            end
        end
    end

endmodule
